// File: rtl/pad_pkg.sv
// Shared types for the output-pad bus memory responder: access sizes and
// responder address-hold states.
package pad_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b11
   } pad_size_t;

   typedef enum logic {
      PAD_IDLE  = 1'b0,
      PAD_ARMED = 1'b1
   } pad_state_t;

   // Encoding 2'b10 is reserved and always rejected.
   function automatic logic size_is_reserved(input logic [1:0] size);
      return (size == 2'b10);
   endfunction

endpackage

// File: rtl/pad_lane_aligner.sv
// Lane steering for byte/half/word accesses: byte enables and shifted store
// data on the way in, right-aligned zero-filled extraction on the way out.
module pad_lane_aligner
   import pad_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] write_data,
   input  logic [31:0] ram_word,
   output logic [3:0]  byte_enable,
   output logic [31:0] write_word,
   output logic [31:0] read_aligned,
   output logic        misaligned
);

   logic [4:0] byte_shift_s;
   logic [4:0] half_shift_s;

   // Bit offsets of the addressed byte and half lanes.
   always_comb begin
      byte_shift_s = {addr_lo, 3'b000};
      half_shift_s = {addr_lo[1], 4'b0000};
   end

   // Per-size lane selection; a misaligned or reserved access enables no bytes.
   always_comb begin
      byte_enable  = 4'b0000;
      write_word   = 32'h0000_0000;
      read_aligned = 32'h0000_0000;
      misaligned   = 1'b0;
      case (size)
         SIZE_BYTE: begin
            byte_enable  = 4'b0001 << addr_lo;
            write_word   = {24'h00_0000, write_data[7:0]} << byte_shift_s;
            read_aligned = (ram_word >> byte_shift_s) & 32'h0000_00FF;
         end
         SIZE_HALF: begin
            misaligned   = addr_lo[0];
            if (addr_lo[0]) begin
               byte_enable = 4'b0000;
            end else begin
               byte_enable = 4'b0011 << {addr_lo[1], 1'b0};
            end
            write_word   = {16'h0000, write_data[15:0]} << half_shift_s;
            read_aligned = (ram_word >> half_shift_s) & 32'h0000_FFFF;
         end
         SIZE_WORD: begin
            misaligned   = (addr_lo != 2'b00);
            if (addr_lo != 2'b00) begin
               byte_enable = 4'b0000;
            end else begin
               byte_enable = 4'b1111;
            end
            write_word   = write_data;
            read_aligned = ram_word;
         end
         default: begin
            misaligned   = size_is_reserved(size) | 1'b1;
            byte_enable  = 4'b0000;
         end
      endcase
   end

endmodule

// File: rtl/pad_memory_responder.sv
// Memory-side slave of the CPU output-pad bus: latches the strobed address,
// serves byte/half/word reads and writes from a word RAM, flags violations.
module pad_memory_responder
   import pad_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned INDEX_WIDTH = $clog2(DEPTH_WORDS)
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        pad_write_address,
   input  logic [31:0] pad_address,
   input  logic        pad_read,
   input  logic        pad_write,
   input  logic [1:0]  pad_data_size,
   input  logic [31:0] pad_write_data,
   output logic [31:0] read_data,
   output logic        read_valid,
   output logic        error,
   input  logic        error_clear
);

   localparam int unsigned ADDR_W = INDEX_WIDTH + 2;

   pad_state_t              state_r;
   logic [ADDR_W-1:0]       addr_r;
   logic [31:0]             mem_r [DEPTH_WORDS];

   logic [ADDR_W-1:0]       eff_addr_s;
   logic [INDEX_WIDTH-1:0]  index_s;
   logic [31:0]             ram_word_s;
   logic [3:0]              byte_enable_s;
   logic [31:0]             write_word_s;
   logic [31:0]             read_aligned_s;
   logic                    misaligned_s;
   logic                    have_addr_s;
   logic                    access_s;
   logic                    violation_s;
   logic                    commit_write_s;
   logic                    unused_addr_bits_s;

   // Address bits above the RAM span alias and are deliberately dropped.
   assign unused_addr_bits_s = ^pad_address[31:ADDR_W];

   // Effective address: a strobed address bypasses the latch in its own cycle.
   always_comb begin
      if (pad_write_address) begin
         eff_addr_s = pad_address[ADDR_W-1:0];
      end else begin
         eff_addr_s = addr_r;
      end
      index_s    = eff_addr_s[ADDR_W-1:2];
      ram_word_s = mem_r[index_s];
   end

   pad_lane_aligner u_lane_aligner (
      .size         (pad_data_size),
      .addr_lo      (eff_addr_s[1:0]),
      .write_data   (pad_write_data),
      .ram_word     (ram_word_s),
      .byte_enable  (byte_enable_s),
      .write_word   (write_word_s),
      .read_aligned (read_aligned_s),
      .misaligned   (misaligned_s)
   );

   // Violation detection and write qualification; reset suppresses any store.
   always_comb begin
      have_addr_s = pad_write_address | (state_r == PAD_ARMED);
      access_s    = pad_read | pad_write;
      if (access_s) begin
         violation_s = misaligned_s | (pad_read & pad_write) | ~have_addr_s;
      end else begin
         violation_s = 1'b0;
      end
      commit_write_s = pad_write & ~violation_s & ~reset;
   end

   // RAM byte-lane merge; contents are intentionally not reset.
   always_ff @(posedge clock) begin
      if (commit_write_s) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_enable_s[b]) begin
               mem_r[index_s][8*b +: 8] <= write_word_s[8*b +: 8];
            end
         end
      end
   end

   // Address-hold FSM with registered read result and sticky error.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r    <= PAD_IDLE;
         addr_r     <= '0;
         read_data  <= 32'h0000_0000;
         read_valid <= 1'b0;
         error      <= 1'b0;
      end else begin
         case (state_r)
            PAD_IDLE: begin
               if (pad_write_address) begin
                  state_r <= PAD_ARMED;
               end
            end
            PAD_ARMED: begin
               state_r <= PAD_ARMED;
            end
            default: begin
               state_r <= PAD_IDLE;
            end
         endcase

         if (pad_write_address) begin
            addr_r <= pad_address[ADDR_W-1:0];
         end

         if (pad_read) begin
            read_valid <= 1'b1;
            if (violation_s) begin
               read_data <= 32'h0000_0000;
            end else begin
               read_data <= read_aligned_s;
            end
         end else begin
            read_valid <= 1'b0;
         end

         // A violation outranks a simultaneous clear.
         if (violation_s) begin
            error <= 1'b1;
         end else if (error_clear) begin
            error <= 1'b0;
         end
      end
   end

endmodule
